// File: rtl/cdb_arbiter_if.sv
// Producer-side handshakes and CDB broadcast bundle for cdb_arbiter.
// The arbiter takes the slave modport; the producers/ROB side takes master.
interface cdb_arbiter_if #(
  parameter int unsigned ROB_WIDTH = 4
);
  logic                 aluValid;
  logic                 aluReady;
  logic [ROB_WIDTH-1:0] aluRobIndex;
  logic [31:0]          aluValue;
  logic                 lsbValid;
  logic                 lsbReady;
  logic [ROB_WIDTH-1:0] lsbRobIndex;
  logic [31:0]          lsbValue;
  logic                 cdbValid;
  logic [ROB_WIDTH-1:0] cdbRobIndex;
  logic [31:0]          cdbValue;
  logic                 cdbFromLsb;

  modport master (
    output aluValid, aluRobIndex, aluValue, lsbValid, lsbRobIndex, lsbValue,
    input  aluReady, lsbReady, cdbValid, cdbRobIndex, cdbValue, cdbFromLsb
  );

  modport slave (
    input  aluValid, aluRobIndex, aluValue, lsbValid, lsbRobIndex, lsbValue,
    output aluReady, lsbReady, cdbValid, cdbRobIndex, cdbValue, cdbFromLsb
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Two per-source result FIFOs (ALU, LSB) drained round-robin onto a registered CDB.
// Index 0 of every per-source array is the ALU, index 1 the LSB.
module cdb_arbiter #(
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned FIFO_WIDTH = 1
) (
  input logic          clockIn,
  input logic          resetIn,
  input logic          clearIn,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned Depth  = 1 << FIFO_WIDTH;
  localparam int unsigned EntryW = ROB_WIDTH + 32;
  localparam int unsigned CountW = FIFO_WIDTH + 1;
  localparam logic SrcAlu = 1'b0;
  localparam logic SrcLsb = 1'b1;

  logic [EntryW-1:0]               mem_q [2][Depth];
  logic [1:0][FIFO_WIDTH-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0][CountW-1:0]          count_q, count_d;
  logic [1:0]                      valid_in, ready, push, pop, nonempty;
  logic [1:0][EntryW-1:0]          wdata, head;
  logic                            grant_valid, grant_src;
  logic                            last_grant_q, last_grant_d;
  logic                            cdb_valid_q, cdb_valid_d;
  logic                            cdb_from_lsb_q, cdb_from_lsb_d;
  logic [ROB_WIDTH-1:0]            cdb_rob_q, cdb_rob_d;
  logic [31:0]                     cdb_value_q, cdb_value_d;

  assign valid_in = {bus.lsbValid, bus.aluValid};
  assign wdata[0] = {bus.aluRobIndex, bus.aluValue};
  assign wdata[1] = {bus.lsbRobIndex, bus.lsbValue};

  // Ready looks only at the registered count: a same-edge pop never frees a slot.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      ready[s]    = count_q[s] != CountW'(Depth);
      nonempty[s] = count_q[s] != '0;
      push[s]     = valid_in[s] && ready[s];
      head[s]     = mem_q[s][rd_ptr_q[s]];
    end
  end

  // On a tie the source that did not win last time is granted.
  always_comb begin
    grant_valid = |nonempty;
    grant_src   = nonempty[1] && (!nonempty[0] || last_grant_q == SrcAlu);
    pop[0]      = grant_valid && (grant_src == SrcAlu);
    pop[1]      = grant_valid && (grant_src == SrcLsb);
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    last_grant_d   = last_grant_q;
    cdb_valid_d    = grant_valid;
    cdb_rob_d      = cdb_rob_q;
    cdb_value_d    = cdb_value_q;
    cdb_from_lsb_d = cdb_from_lsb_q;
    for (int s = 0; s < 2; s++) begin
      if (push[s]) wr_ptr_d[s] = wr_ptr_q[s] + FIFO_WIDTH'(1);
      if (pop[s])  rd_ptr_d[s] = rd_ptr_q[s] + FIFO_WIDTH'(1);
      count_d[s] = count_q[s] + CountW'(push[s]) - CountW'(pop[s]);
    end
    if (grant_valid) begin
      cdb_rob_d      = grant_src ? head[1][EntryW-1:32] : head[0][EntryW-1:32];
      cdb_value_d    = grant_src ? head[1][31:0] : head[0][31:0];
      cdb_from_lsb_d = grant_src;
      last_grant_d   = grant_src;
    end
    // A flush drops every buffered result, the pending push and the head being granted.
    if (clearIn) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      last_grant_d   = last_grant_q;
      cdb_valid_d    = 1'b0;
      cdb_rob_d      = cdb_rob_q;
      cdb_value_d    = cdb_value_q;
      cdb_from_lsb_d = cdb_from_lsb_q;
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      last_grant_q   <= SrcLsb;
      cdb_valid_q    <= 1'b0;
      cdb_rob_q      <= '0;
      cdb_value_q    <= '0;
      cdb_from_lsb_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      last_grant_q   <= last_grant_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_rob_q      <= cdb_rob_d;
      cdb_value_q    <= cdb_value_d;
      cdb_from_lsb_q <= cdb_from_lsb_d;
    end
  end

  always_ff @(posedge clockIn) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s] && !clearIn && !resetIn) mem_q[s][wr_ptr_q[s]] <= wdata[s];
    end
  end

  assign bus.aluReady    = ready[0];
  assign bus.lsbReady    = ready[1];
  assign bus.cdbValid    = cdb_valid_q;
  assign bus.cdbRobIndex = cdb_rob_q;
  assign bus.cdbValue    = cdb_value_q;
  assign bus.cdbFromLsb  = cdb_from_lsb_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table for the basic flows, a queue-based
// reference model with a broadcast scoreboard, and hand-written multi-cycle corner sequences.
module tb_cdb_arbiter;
  localparam int unsigned RobW = 4;

  logic clockIn = 1'b0;
  logic resetIn = 1'b1;
  logic clearIn = 1'b0;

  cdb_arbiter_if #(.ROB_WIDTH(RobW)) bus ();

  cdb_arbiter #(.ROB_WIDTH(RobW), .FIFO_WIDTH(1)) dut (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .clearIn (clearIn),
    .bus     (bus)
  );

  always #5 clockIn = ~clockIn;

  typedef struct packed {
    logic [RobW-1:0] idx;
    logic [31:0]     val;
  } ent_t;

  typedef struct packed {
    logic [RobW-1:0] idx;
    logic [31:0]     val;
    logic            from_lsb;
  } bc_t;

  typedef struct packed {
    logic rst;
    logic av; logic [RobW-1:0] ai; logic [31:0] ad;
    logic lv; logic [RobW-1:0] li; logic [31:0] ld;
    logic e_ar; logic e_lr; logic e_cv; logic [RobW-1:0] e_ci; logic [31:0] e_cd; logic e_cl;
  } vec_t;

  ent_t mq_alu[$];
  ent_t mq_lsb[$];
  bc_t  sb[$];
  logic m_last  = 1'b1;
  logic m_valid = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   lsb_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.aluValid = 1'b0; bus.aluRobIndex = '0; bus.aluValue = '0;
    bus.lsbValid = 1'b0; bus.lsbRobIndex = '0; bus.lsbValue = '0;
  endtask

  function automatic logic model_grants_alu();
    return (mq_alu.size() != 0) && !((mq_lsb.size() != 0) && m_last == 1'b0);
  endfunction

  // One clock: model the edge from the values driven before it, then compare at edge+1.
  task automatic tick();
    logic acc_a, acc_l, ne_a, ne_l, g_v, g_l;
    ent_t e;
    bc_t  b;
    ne_a  = mq_alu.size() != 0;
    ne_l  = mq_lsb.size() != 0;
    acc_a = bus.aluValid && (mq_alu.size() < 2);
    acc_l = bus.lsbValid && (mq_lsb.size() < 2);
    g_v   = ne_a || ne_l;
    g_l   = ne_l && (!ne_a || !m_last);
    if (!resetIn) begin
      check("alu_ready", {63'd0, bus.aluReady}, {63'd0, mq_alu.size() < 2});
      check("lsb_ready", {63'd0, bus.lsbReady}, {63'd0, mq_lsb.size() < 2});
    end
    @(posedge clockIn);
    #1;
    if (resetIn) begin
      mq_alu.delete(); mq_lsb.delete(); sb.delete();
      m_valid = 1'b0; m_last = 1'b1;
    end else if (clearIn) begin
      mq_alu.delete(); mq_lsb.delete();
      m_valid = 1'b0;
    end else begin
      m_valid = g_v;
      if (g_v) begin
        if (g_l) e = mq_lsb.pop_front();
        else     e = mq_alu.pop_front();
        b = {e.idx, e.val, g_l};
        sb.push_back(b);
        m_last = g_l;
      end
      if (acc_a) mq_alu.push_back({bus.aluRobIndex, bus.aluValue});
      if (acc_l) mq_lsb.push_back({bus.lsbRobIndex, bus.lsbValue});
    end
    check("cdb_valid", {63'd0, bus.cdbValid}, {63'd0, m_valid});
    if (bus.cdbValid === 1'b1) begin
      check("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check("cdb_idx", {60'd0, bus.cdbRobIndex}, {60'd0, b.idx});
        check("cdb_val", {32'd0, bus.cdbValue}, {32'd0, b.val});
        check("cdb_from", {63'd0, bus.cdbFromLsb}, {63'd0, b.from_lsb});
        if (b.from_lsb) lsb_seen++;
      end
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_alu_ready"}, {63'd0, bus.aluReady}, 64'd1);
    check({tag, "_lsb_ready"}, {63'd0, bus.lsbReady}, 64'd1);
    check({tag, "_cdb_valid"}, {63'd0, bus.cdbValid}, 64'd0);
    check({tag, "_cdb_idx"}, {60'd0, bus.cdbRobIndex}, 64'd0);
    check({tag, "_cdb_val"}, {32'd0, bus.cdbValue}, 64'd0);
    check({tag, "_cdb_from"}, {63'd0, bus.cdbFromLsb}, 64'd0);
  endtask

  function automatic vec_t mk(logic rst, logic av, logic [RobW-1:0] ai, logic [31:0] ad,
                              logic lv, logic [RobW-1:0] li, logic [31:0] ld,
                              logic e_ar, logic e_lr, logic e_cv, logic [RobW-1:0] e_ci,
                              logic [31:0] e_cd, logic e_cl);
    return {rst, av, ai, ad, lv, li, ld, e_ar, e_lr, e_cv, e_ci, e_cd, e_cl};
  endfunction

  vec_t vecs[10];

  initial begin
    int k, j, lsb_base;
    logic saw_bp, found;

    // Single ALU result, then reset and simultaneous ALU/LSB arrivals.
    vecs[0] = mk(0, 1, 3, 32'h1234, 0, 0, 0,          1, 1, 0, 0, 0, 0);
    vecs[1] = mk(0, 0, 0, 0,        0, 0, 0,          1, 1, 1, 3, 32'h1234, 0);
    vecs[2] = mk(0, 0, 0, 0,        0, 0, 0,          1, 1, 0, 0, 0, 0);
    vecs[3] = mk(1, 0, 0, 0,        0, 0, 0,          1, 1, 0, 0, 0, 0);
    vecs[4] = mk(0, 1, 1, 32'hA,    1, 2, 32'hB,      1, 1, 0, 0, 0, 0);
    vecs[5] = mk(0, 1, 4, 32'hC,    1, 5, 32'hD,      1, 0, 1, 1, 32'hA, 0);
    vecs[6] = mk(0, 0, 0, 0,        0, 0, 0,          1, 1, 1, 2, 32'hB, 1);
    vecs[7] = mk(0, 0, 0, 0,        0, 0, 0,          1, 1, 1, 4, 32'hC, 0);
    vecs[8] = mk(0, 0, 0, 0,        0, 0, 0,          1, 1, 1, 5, 32'hD, 1);
    vecs[9] = mk(0, 0, 0, 0,        0, 0, 0,          1, 1, 0, 0, 0, 0);

    idle();
    resetIn = 1'b1;
    tick();
    tick();
    check_reset_outs("reset");
    resetIn = 1'b0;

    for (int i = 0; i < 10; i++) begin
      resetIn = vecs[i].rst;
      bus.aluValid = vecs[i].av; bus.aluRobIndex = vecs[i].ai; bus.aluValue = vecs[i].ad;
      bus.lsbValid = vecs[i].lv; bus.lsbRobIndex = vecs[i].li; bus.lsbValue = vecs[i].ld;
      tick();
      check($sformatf("vec%0d_alu_ready", i), {63'd0, bus.aluReady}, {63'd0, vecs[i].e_ar});
      check($sformatf("vec%0d_lsb_ready", i), {63'd0, bus.lsbReady}, {63'd0, vecs[i].e_lr});
      check($sformatf("vec%0d_cdb_valid", i), {63'd0, bus.cdbValid}, {63'd0, vecs[i].e_cv});
      if (vecs[i].e_cv || vecs[i].rst) begin
        check($sformatf("vec%0d_cdb_idx", i), {60'd0, bus.cdbRobIndex}, {60'd0, vecs[i].e_ci});
        check($sformatf("vec%0d_cdb_val", i), {32'd0, bus.cdbValue}, {32'd0, vecs[i].e_cd});
        check($sformatf("vec%0d_cdb_from", i), {63'd0, bus.cdbFromLsb}, {63'd0, vecs[i].e_cl});
      end
    end
    resetIn = 1'b0;
    idle();

    // Backpressure and wrap: LSB held valid, ALU pushing every cycle.
    k = 0; j = 0; saw_bp = 1'b0; lsb_base = lsb_seen;
    for (int c = 0; c < 40 && k < 6; c++) begin
      bus.lsbValid = 1'b1; bus.lsbRobIndex = RobW'(k); bus.lsbValue = 32'h100 + k;
      bus.aluValid = 1'b1; bus.aluRobIndex = RobW'(8 + (j % 8)); bus.aluValue = 32'hA000 + j;
      if (mq_lsb.size() < 2) k++;
      else saw_bp = 1'b1;
      if (mq_alu.size() < 2) j++;
      tick();
    end
    check("bp_all_lsb_accepted", 64'(k), 64'd6);
    check("bp_lsb_ready_dropped", {63'd0, saw_bp}, 64'd1);
    idle();
    for (int c = 0; c < 8; c++) tick();
    check("bp_lsb_broadcasts", 64'(lsb_seen - lsb_base), 64'd6);
    check("bp_drained", 64'(mq_alu.size() + mq_lsb.size() + sb.size()), 64'd0);

    // Clear mid-flight with a fresh ALU push offered at the clear edge.
    for (int c = 0; c < 2; c++) begin
      bus.aluValid = 1'b1; bus.aluRobIndex = RobW'(c); bus.aluValue = 32'hC000 + c;
      bus.lsbValid = 1'b1; bus.lsbRobIndex = RobW'(c + 4); bus.lsbValue = 32'hD000 + c;
      tick();
    end
    clearIn = 1'b1;
    bus.aluValid = 1'b1; bus.aluRobIndex = 4'd7; bus.aluValue = 32'hDEAD;
    bus.lsbValid = 1'b0;
    tick();
    clearIn = 1'b0;
    idle();
    check("clr_cdb_valid", {63'd0, bus.cdbValid}, 64'd0);
    check("clr_alu_ready", {63'd0, bus.aluReady}, 64'd1);
    check("clr_lsb_ready", {63'd0, bus.lsbReady}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("clr_quiet%0d", c), {63'd0, bus.cdbValid}, 64'd0);
    end

    // Reset wins over clear; last grant was ALU before reset, so the tie proves the reset value.
    bus.aluValid = 1'b1; bus.aluRobIndex = 4'd1; bus.aluValue = 32'h51;
    tick();
    bus.aluRobIndex = 4'd2; bus.aluValue = 32'h52;
    bus.lsbValid = 1'b1; bus.lsbRobIndex = 4'd3; bus.lsbValue = 32'h53;
    tick();
    resetIn = 1'b1; clearIn = 1'b1;
    idle();
    tick();
    resetIn = 1'b0; clearIn = 1'b0;
    check_reset_outs("rst_over_clr");
    bus.aluValid = 1'b1; bus.aluRobIndex = 4'd9; bus.aluValue = 32'h61;
    bus.lsbValid = 1'b1; bus.lsbRobIndex = 4'd10; bus.lsbValue = 32'h62;
    tick();
    idle();
    tick();
    check("tie_after_reset_valid", {63'd0, bus.cdbValid}, 64'd1);
    check("tie_after_reset_alu", {63'd0, bus.cdbFromLsb}, 64'd0);
    tick();
    check("tie_after_reset_lsb", {63'd0, bus.cdbFromLsb}, 64'd1);
    tick();

    // Full ALU FIFO granted: ready stays low through the pop edge, rises after it.
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    found = 1'b0; j = 0; k = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      bus.aluValid = 1'b1; bus.aluRobIndex = RobW'(j); bus.aluValue = 32'hE000 + j;
      bus.lsbValid = 1'b1; bus.lsbRobIndex = RobW'(k); bus.lsbValue = 32'hF000 + k;
      if (mq_alu.size() == 2 && model_grants_alu()) begin
        found = 1'b1;
      end else begin
        if (mq_alu.size() < 2) j++;
        if (mq_lsb.size() < 2) k++;
        tick();
      end
    end
    check("full_grant_reached", {63'd0, found}, 64'd1);
    if (found) begin
      check("full_pop_cycle_ready", {63'd0, bus.aluReady}, 64'd0);
      if (mq_lsb.size() < 2) k++;
      tick();
      check("full_after_pop_ready", {63'd0, bus.aluReady}, 64'd1);
      bus.lsbRobIndex = RobW'(k); bus.lsbValue = 32'hF000 + k;
      tick();
      check("full_refilled_ready", {63'd0, bus.aluReady}, 64'd0);
    end
    idle();
    for (int c = 0; c < 8; c++) tick();
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
